// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - packs symbolic micro-ops into 16-bit words and loads them into instruction memory
// Optional INSTR_ENC_CKSUM_EN adds cksum_o, a running XOR of every word written.
module instr_encoder_loader #(
  parameter int AW = 8
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          start_i,
  input  logic          finish_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [3:0]    mnem_i,
  input  logic [2:0]    dr_i,
  input  logic [2:0]    sa_i,
  input  logic [2:0]    sb_i,
  input  logic [5:0]    imm_i,
  output logic          imem_we_o,
  output logic [AW-1:0] imem_addr_o,
  output logic [15:0]   imem_wdata_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
`ifdef INSTR_ENC_CKSUM_EN
  output logic [15:0]   cksum_o,
`endif
  output logic [AW:0]   count_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEAL, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          err_q, err_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   cksum_q, cksum_d;
  logic          handshake;
  logic          legal;
  logic [15:0]   enc_word;

  function automatic logic [15:0] encode(input logic [3:0] m, input logic [2:0] dr,
                                         input logic [2:0] sa, input logic [2:0] sb,
                                         input logic [5:0] imm);
    logic [15:0] w;
    case (m)
      4'd0:    w = 16'h0000;
      4'd1:    w = 16'h0001;
      4'd2:    w = {4'h2, sa, dr, imm};
      4'd3:    w = {4'h4, sa, sb, imm};
      4'd4:    w = {4'h5, sa, dr, imm};
      4'd5:    w = {4'h6, sa, dr, imm};
      4'd6:    w = {4'h7, sa, dr, imm};
      4'd7:    w = {4'hF, sa, sb, dr, 3'd0};
      4'd8:    w = {4'hF, sa, sb, dr, 3'd1};
      // shifts carry no second register operand
      4'd9:    w = {4'hF, sa, 3'd0, dr, 3'd2};
      4'd10:   w = {4'hF, sa, 3'd0, dr, 3'd3};
      4'd11:   w = {4'hF, sa, 3'd0, dr, 3'd4};
      4'd12:   w = {4'hF, sa, sb, dr, 3'd5};
      4'd13:   w = {4'hF, sa, sb, dr, 3'd6};
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  // last slot stays free so FINISH can always seal with HALT
  assign in_ready_o = (state_q == S_LOAD) && (wr_ptr_q != {AW{1'b1}});
  assign handshake  = in_valid_i && in_ready_o;
  assign legal      = (mnem_i <= 4'd13);
  assign enc_word   = encode(mnem_i, dr_i, sa_i, sb_i, imm_i);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cksum_d  = cksum_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d  = S_LOAD;
          wr_ptr_d = '0;
          count_d  = '0;
          err_d    = 1'b0;
          cksum_d  = 16'h0000;
        end
      end
      S_LOAD: begin
        if (handshake) begin
          if (legal) begin
            we_d     = 1'b1;
            addr_d   = wr_ptr_q;
            wdata_d  = enc_word;
            wr_ptr_d = wr_ptr_q + AW'(1);
            count_d  = count_q + (AW+1)'(1);
            cksum_d  = cksum_q ^ enc_word;
          end else begin
            err_d = 1'b1;
          end
        end
        if (finish_i) state_d = S_SEAL;
      end
      S_SEAL: begin
        we_d    = 1'b1;
        addr_d  = wr_ptr_q;
        wdata_d = 16'h0001;
        count_d = count_q + (AW+1)'(1);
        cksum_d = cksum_q ^ 16'h0001;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 16'h0000;
      cksum_q  <= 16'h0000;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cksum_q  <= cksum_d;
    end
  end

  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign busy_o       = (state_q == S_LOAD) || (state_q == S_SEAL);
  assign done_o       = (state_q == S_DONE);
  assign err_o        = err_q;
  assign count_o      = count_q;
`ifdef INSTR_ENC_CKSUM_EN
  assign cksum_o      = cksum_q;
`else
  logic unused_cksum;
  assign unused_cksum = ^cksum_q;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - self-checking bench for instr_encoder_loader
// Directed scenarios plus randomized programs checked against an arithmetic encoding model.
module tb_instr_encoder_loader;
  localparam int AW = 4;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, finish, in_valid, in_ready;
  logic [3:0]    mnem;
  logic [2:0]    dr, sa, sb;
  logic [5:0]    imm;
  logic          imem_we, busy, done, err;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_wdata;
  logic [AW:0]   count;
`ifdef INSTR_ENC_CKSUM_EN
  logic [15:0]   cksum;
`endif

  instr_encoder_loader #(.AW(AW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .finish_i(finish),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .mnem_i(mnem),
    .dr_i(dr), .sa_i(sa), .sb_i(sb), .imm_i(imm),
    .imem_we_o(imem_we), .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata),
    .busy_o(busy), .done_o(done), .err_o(err),
`ifdef INSTR_ENC_CKSUM_EN
    .cksum_o(cksum),
`endif
    .count_o(count)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [AW-1:0] cap_a[$];
  logic [15:0]   cap_d[$];

  always @(negedge clk) if (imem_we === 1'b1) begin
    cap_a.push_back(imem_addr);
    cap_d.push_back(imem_wdata);
  end

  // Word = OP*4096 + RS*512 + RT*64 + (RD*8 + FUNCT | IMM)
  function automatic logic [15:0] model_enc(int m, int d, int a, int b, int im);
    int fn, rt, op;
    if (m == 0) return 16'h0000;
    if (m == 1) return 16'h0001;
    if (m >= 7) begin
      fn = m - 7;
      rt = (fn >= 2 && fn <= 4) ? 0 : b;
      return 16'(15*4096 + a*512 + rt*64 + d*8 + fn);
    end
    if (m == 3) begin op = 4; rt = b; end
    else begin op = (m == 2) ? 2 : m + 1; rt = d; end
    return 16'(op*4096 + a*512 + rt*64 + im);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_op(int m, int d, int a, int b, int im);
    in_valid = 1'b1; mnem = 4'(m); dr = 3'(d); sa = 3'(a); sb = 3'(b); imm = 6'(im);
  endtask

  task automatic begin_program();
    start = 1'b1; tick(); start = 1'b0;
    cap_a.delete(); cap_d.delete();
  endtask

  task automatic test_reset();
    tick();
    vectors++; if (imem_we !== 1'b0) begin miscompares++; $display("FAIL reset_we got %b exp 0", imem_we); end
    vectors++; if (imem_addr !== '0) begin miscompares++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
    vectors++; if (imem_wdata !== 16'h0) begin miscompares++; $display("FAIL reset_wdata got %h exp 0", imem_wdata); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b exp 0", in_ready); end
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL reset_busy_done got %b%b exp 00", busy, done); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b exp 0", err); end
    vectors++; if (count !== '0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", count); end
  endtask

  task automatic test_encode();
    int m[4]    = '{7, 4, 3, 9};
    int d[4]    = '{3, 2, 5, 5};
    int a[4]    = '{1, 1, 4, 6};
    int b[4]    = '{2, 6, 7, 7};
    int im[4]   = '{63, 5, 63, 21};
    logic [15:0] ex[4] = '{16'hF298, 16'h5285, 16'h49FF, 16'hFC2A};
    begin_program();
    vectors++; if (in_ready !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL load_entry ready/busy got %b%b exp 11", in_ready, busy); end
    for (int i = 0; i < 4; i++) begin
      drive_op(m[i], d[i], a[i], b[i], im[i]);
      tick();
      in_valid = 1'b0;
      vectors++; if (imem_we !== 1'b1 || imem_addr !== AW'(i) || imem_wdata !== ex[i] || count !== (AW+1)'(i+1))
        begin miscompares++; $display("FAIL encode_%0d got we=%b a=%0d d=%h c=%0d exp we=1 a=%0d d=%h c=%0d", i, imem_we, imem_addr, imem_wdata, count, i, ex[i], i+1); end
    end
    finish = 1'b1; tick(); finish = 1'b0;
    vectors++; if (imem_we !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL seal_cycle got we=%b busy=%b exp we=0 busy=1", imem_we, busy); end
    tick();
    vectors++; if (imem_we !== 1'b1 || imem_addr !== AW'(4) || imem_wdata !== 16'h0001 || count !== (AW+1)'(5))
      begin miscompares++; $display("FAIL halt_write got we=%b a=%0d d=%h c=%0d exp we=1 a=4 d=0001 c=5", imem_we, imem_addr, imem_wdata, count); end
    vectors++; if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin miscompares++; $display("FAIL done_flags got done=%b busy=%b rdy=%b exp 1 0 0", done, busy, in_ready); end
    tick();
    vectors++; if (imem_we !== 1'b0 || done !== 1'b1 || count !== (AW+1)'(5)) begin miscompares++; $display("FAIL done_hold got we=%b done=%b c=%0d exp 0 1 5", imem_we, done, count); end
  endtask

  task automatic test_full();
    begin_program();
    drive_op(0, 1, 2, 3, 4);
    for (int i = 0; i < DEPTH + 2; i++) tick();
    in_valid = 1'b0;
    vectors++; if (count !== (AW+1)'(DEPTH-1) || in_ready !== 1'b0 || err !== 1'b0)
      begin miscompares++; $display("FAIL full_stop got c=%0d rdy=%b err=%b exp c=%0d rdy=0 err=0", count, in_ready, err, DEPTH-1); end
    vectors++; if (cap_a.size() != DEPTH-1) begin miscompares++; $display("FAIL full_writes got %0d exp %0d", cap_a.size(), DEPTH-1); end
    finish = 1'b1; tick(); finish = 1'b0; tick();
    vectors++; if (imem_we !== 1'b1 || imem_addr !== AW'(DEPTH-1) || imem_wdata !== 16'h0001 || count !== (AW+1)'(DEPTH))
      begin miscompares++; $display("FAIL full_halt got we=%b a=%0d d=%h c=%0d exp we=1 a=%0d d=0001 c=%0d", imem_we, imem_addr, imem_wdata, count, DEPTH-1, DEPTH); end
    tick();
  endtask

  task automatic test_illegal_and_reset();
    begin_program();
    drive_op(15, 1, 2, 3, 4); tick(); in_valid = 1'b0;
    vectors++; if (imem_we !== 1'b0 || count !== '0 || err !== 1'b1) begin miscompares++; $display("FAIL illegal got we=%b c=%0d err=%b exp 0 0 1", imem_we, count, err); end
    drive_op(7, 3, 1, 2, 0); tick(); in_valid = 1'b0;
    vectors++; if (imem_we !== 1'b1 || imem_addr !== '0 || count !== (AW+1)'(1) || err !== 1'b1)
      begin miscompares++; $display("FAIL after_illegal got we=%b a=%0d c=%0d err=%b exp 1 0 1 1", imem_we, imem_addr, count, err); end
    finish = 1'b1; tick(); finish = 1'b0; tick(); tick();
    vectors++; if (done !== 1'b1 || err !== 1'b1 || count !== (AW+1)'(2)) begin miscompares++; $display("FAIL err_sticky got done=%b err=%b c=%0d exp 1 1 2", done, err, count); end
    begin_program();
    vectors++; if (err !== 1'b0 || count !== '0 || busy !== 1'b1) begin miscompares++; $display("FAIL restart got err=%b c=%0d busy=%b exp 0 0 1", err, count, busy); end
    drive_op(7, 3, 1, 2, 0); tick();
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (imem_we !== 1'b0 || imem_addr !== '0 || imem_wdata !== 16'h0 || count !== '0 || busy !== 1'b0 || in_ready !== 1'b0)
      begin miscompares++; $display("FAIL async_reset got we=%b a=%0d d=%h c=%0d busy=%b rdy=%b exp all 0", imem_we, imem_addr, imem_wdata, count, busy, in_ready); end
    tick(); rst_n = 1'b1; tick(); in_valid = 1'b0;
    vectors++; if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || imem_we !== 1'b0)
      begin miscompares++; $display("FAIL post_reset_idle got busy=%b rdy=%b done=%b we=%b exp 0", busy, in_ready, done, imem_we); end
  endtask

  task automatic test_back_to_back();
    begin_program();
    drive_op(7, 3, 1, 2, 0); tick();
    drive_op(4, 2, 1, 0, 5); finish = 1'b1; tick();
    in_valid = 1'b0; finish = 1'b0;
    vectors++; if (imem_we !== 1'b1 || imem_addr !== AW'(1) || imem_wdata !== 16'h5285)
      begin miscompares++; $display("FAIL b2b_word got we=%b a=%0d d=%h exp 1 1 5285", imem_we, imem_addr, imem_wdata); end
    tick();
    vectors++; if (imem_we !== 1'b1 || imem_addr !== AW'(2) || imem_wdata !== 16'h0001 || count !== (AW+1)'(3) || done !== 1'b1)
      begin miscompares++; $display("FAIL b2b_halt got we=%b a=%0d d=%h c=%0d done=%b exp 1 2 0001 3 1", imem_we, imem_addr, imem_wdata, count, done); end
`ifdef INSTR_ENC_CKSUM_EN
    vectors++; if (cksum !== 16'hA01C) begin miscompares++; $display("FAIL cksum got %h exp A01C", cksum); end
`endif
    tick();
  endtask

  task automatic test_random_programs();
    for (int run = 0; run < 10; run++) begin
      logic [AW-1:0] ea[$];
      logic [15:0]   ed[$];
      int ptr = 0, ecount = 0, ncyc, m;
      bit eerr = 0, ready_m, v;
      logic [15:0] eck = 16'h0, w;
      ncyc = $urandom_range(1, 24);
      begin_program();
      for (int c = 0; c < ncyc; c++) begin
        ready_m = (ptr < DEPTH - 1);
        vectors++; if (in_ready !== ready_m) begin miscompares++; $display("FAIL rnd_ready run%0d cyc%0d got %b exp %b", run, c, in_ready, ready_m); end
        v = ($urandom_range(0, 3) != 0);
        m = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 15) : $urandom_range(0, 13);
        drive_op(m, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 63));
        in_valid = v;
        finish = (c == ncyc - 1);
        if (v && ready_m) begin
          if (m >= 14) eerr = 1;
          else begin
            w = model_enc(m, dr, sa, sb, imm);
            ea.push_back(AW'(ptr)); ed.push_back(w);
            ptr++; ecount++; eck ^= w;
          end
        end
        tick();
      end
      in_valid = 1'b0; finish = 1'b0;
      ea.push_back(AW'(ptr)); ed.push_back(16'h0001); ecount++; eck ^= 16'h0001;
      tick(); tick();
      vectors++; if (done !== 1'b1 || count !== (AW+1)'(ecount) || err !== eerr)
        begin miscompares++; $display("FAIL rnd_end run%0d got done=%b c=%0d err=%b exp 1 %0d %b", run, done, count, err, ecount, eerr); end
`ifdef INSTR_ENC_CKSUM_EN
      vectors++; if (cksum !== eck) begin miscompares++; $display("FAIL rnd_cksum run%0d got %h exp %h", run, cksum, eck); end
`endif
      vectors++; if (cap_a.size() != ea.size()) begin miscompares++; $display("FAIL rnd_nwrites run%0d got %0d exp %0d", run, cap_a.size(), ea.size()); end
      for (int i = 0; i < ea.size() && i < cap_a.size(); i++) begin
        vectors++; if (cap_a[i] !== ea[i] || cap_d[i] !== ed[i])
          begin miscompares++; $display("FAIL rnd_word run%0d idx%0d got a=%0d d=%h exp a=%0d d=%h", run, i, cap_a[i], cap_d[i], ea[i], ed[i]); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    mnem = '0; dr = '0; sa = '0; sb = '0; imm = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    test_reset();
    test_encode();
    test_full();
    test_illegal_and_reset();
    test_back_to_back();
    test_random_programs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
